spif_rdseq: RTL and testbench

Read sequencer for the SPI flash byte engine `sflash`. Accepts a read request (24-bit byte address, length) and drives the engine through the whole transaction:
- command byte;
- address;
- mode/dummy bytes;
- N data bytes;
- chip-select release.

Data bytes are returned on a valid/ready stream. It sits between the CPU/boot loader fetch logic and `sflash`, and is the only master of the engine's `wr`/`format` inputs.

---
 rtl/spif_pkg.sv | 26 ++
 rtl/spif_rdseq.sv | 178 +++++++++++++++++
 tb/tb_spif_rdseq.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spif_pkg.sv
// Shared constants for the SPI flash read sequencer: sflash bus formats,
// read opcodes and the sequencer state encoding.
package spif_pkg;

   localparam logic [2:0] FMT_IDLE   = 3'b000;
   localparam logic [2:0] FMT_SDR_TX = 3'b010;
   localparam logic [2:0] FMT_SDR_RX = 3'b011;
   localparam logic [2:0] FMT_DDR_TX = 3'b100;
   localparam logic [2:0] FMT_DDR_RX = 3'b101;
   localparam logic [2:0] FMT_QDR_TX = 3'b110;
   localparam logic [2:0] FMT_QDR_RX = 3'b111;

   localparam logic [7:0] OP_FAST_READ = 8'h0B;
   localparam logic [7:0] OP_QIO_READ  = 8'hEB;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_MODE,
      ST_DUMMY,
      ST_DATA,
      ST_GAP
   } seq_state_t;

endpackage

// File: rtl/spif_rdseq.sv
// Read sequencer driving the sflash byte engine through command, address,
// dummy and data bytes. Define FLASH_QUAD_EN for the quad I/O 0xEB sequence.
module spif_rdseq
   import spif_pkg::*;
#(
   parameter int         LEN_W    = 16,
   parameter logic [3:0] PRESCALE = 4'd1,
   parameter int         CS_GAP   = 3
) (
   input  logic             clk,
   input  logic             arstn,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [23:0]      req_addr,
   input  logic [LEN_W-1:0] req_len,
   output logic [7:0]       rd_data,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic             busy,
   input  logic             fl_ready,
   output logic             fl_wr,
   output logic             fl_who,
   output logic [7:0]       fl_din,
   output logic [2:0]       fl_format,
   output logic [3:0]       fl_prescale,
   input  logic [7:0]       fl_dout
);

`ifdef FLASH_QUAD_EN
   localparam logic [7:0] OPCODE     = OP_QIO_READ;
   localparam logic [2:0] ADDR_FMT   = FMT_QDR_TX;
   localparam logic [2:0] RX_FMT     = FMT_QDR_RX;
   localparam logic [1:0] DUMMY_LAST = 2'd1;
   localparam bit         HAS_MODE   = 1'b1;
`else
   localparam logic [7:0] OPCODE     = OP_FAST_READ;
   localparam logic [2:0] ADDR_FMT   = FMT_SDR_TX;
   localparam logic [2:0] RX_FMT     = FMT_SDR_RX;
   localparam logic [1:0] DUMMY_LAST = 2'd0;
   localparam bit         HAS_MODE   = 1'b0;
`endif

   localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

   seq_state_t       r_state;
   seq_state_t       w_state_nxt;
   logic [23:0]      r_addr;
   logic [LEN_W-1:0] r_len_cnt;
   logic [1:0]       r_idx;
   logic [GAP_W-1:0] r_gap_cnt;
   logic             r_pend;
   logic             r_seen_low;
   logic             r_fl_wr;
   logic [7:0]       r_fl_din;
   logic [2:0]       r_fl_format;
   logic [7:0]       r_rd_data;
   logic             r_rd_valid;

   logic             w_issue;
   logic             w_done;
   logic             w_active;
   logic [7:0]       w_din;
   logic [2:0]       w_fmt;

   // NOTE: every always_comb output gets a default first, so no path infers a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_din       = 8'hFF;
      w_fmt       = FMT_IDLE;
      w_done      = r_pend && r_seen_low && fl_ready;
      case (r_state)
         ST_IDLE:  if (req_valid) w_state_nxt = ST_CMD;
         ST_CMD: begin
            w_din = OPCODE;
            w_fmt = FMT_SDR_TX;
            if (w_done) w_state_nxt = ST_ADDR;
         end
         ST_ADDR: begin
            case (r_idx)
               2'd0:    w_din = r_addr[23:16];
               2'd1:    w_din = r_addr[15:8];
               default: w_din = r_addr[7:0];
            endcase
            w_fmt = ADDR_FMT;
            if (w_done && r_idx == 2'd2) w_state_nxt = HAS_MODE ? ST_MODE : ST_DUMMY;
         end
         ST_MODE: begin
            // Mode byte 0x00 keeps the device out of continuous-read mode.
            w_din = 8'h00;
            w_fmt = ADDR_FMT;
            if (w_done) w_state_nxt = ST_DUMMY;
         end
         ST_DUMMY: begin
            w_fmt = RX_FMT;
            if (w_done && r_idx == DUMMY_LAST) w_state_nxt = ST_DATA;
         end
         ST_DATA: begin
            w_fmt = RX_FMT;
            if (w_done && r_len_cnt == '0) w_state_nxt = ST_GAP;
         end
         ST_GAP:   if (r_gap_cnt == '0) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
      w_active = r_state inside {ST_CMD, ST_ADDR, ST_MODE, ST_DUMMY, ST_DATA};
      // A data byte waits until the previous one has been taken by the consumer.
      w_issue  = w_active && !r_pend && !r_fl_wr && fl_ready &&
                 !(r_state == ST_DATA && r_rd_valid);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         r_addr      <= '0;
         r_len_cnt   <= '0;
         r_idx       <= '0;
         r_gap_cnt   <= '0;
         r_pend      <= 1'b0;
         r_seen_low  <= 1'b0;
         r_fl_wr     <= 1'b0;
         r_fl_din    <= '0;
         r_fl_format <= FMT_IDLE;
         r_rd_data   <= '0;
         r_rd_valid  <= 1'b0;
      end else begin
         r_fl_wr <= w_issue;
         if (w_issue) begin
            r_fl_din    <= w_din;
            r_fl_format <= w_fmt;
            r_pend      <= 1'b1;
            r_seen_low  <= 1'b0;
         end else if (r_pend && !fl_ready) begin
            r_seen_low  <= 1'b1;
         end

         if (w_done) begin
            r_pend <= 1'b0;
            r_idx  <= (w_state_nxt != r_state) ? 2'd0 : r_idx + 2'd1;
         end

         if (r_state == ST_IDLE && req_valid) begin
            r_addr    <= req_addr;
            r_len_cnt <= req_len;
         end

         if (w_done && r_state == ST_DATA) begin
            r_rd_data  <= fl_dout;
            r_rd_valid <= 1'b1;
            if (r_len_cnt != '0) r_len_cnt <= r_len_cnt - LEN_W'(1);
         end else if (r_rd_valid && rd_ready) begin
            r_rd_valid <= 1'b0;
         end

         // Last completion lands with the engine ready, so CS# release is safe here.
         if (w_done && r_state == ST_DATA && r_len_cnt == '0) begin
            r_fl_format <= FMT_IDLE;
            r_gap_cnt   <= GAP_W'(CS_GAP - 1);
         end else if (r_state == ST_GAP && r_gap_cnt != '0) begin
            r_gap_cnt   <= r_gap_cnt - GAP_W'(1);
         end
      end
   end

   assign req_ready   = (r_state == ST_IDLE);
   assign busy        = (r_state != ST_IDLE);
   assign fl_wr       = r_fl_wr;
   assign fl_who      = 1'b0;
   assign fl_din      = r_fl_din;
   assign fl_format   = r_fl_format;
   assign fl_prescale = PRESCALE;
   assign rd_data     = r_rd_data;
   assign rd_valid    = r_rd_valid;

endmodule

// File: tb/tb_spif_rdseq.sv
// Self-checking bench for spif_rdseq: a behavioural sflash responder, a
// transaction-level reference model of the expected strobes and data, and a strobe-rule monitor.
module tb_spif_rdseq;

   localparam int TB_LEN_W = 4;
   localparam int CS_GAP   = 3;
   localparam int BUDGET   = 4000;

`ifdef FLASH_QUAD_EN
   localparam int         HDR_N  = 7;
   localparam logic [7:0] OPC    = 8'hEB;
   localparam logic [2:0] A_FMT  = 3'b110;
   localparam logic [2:0] RX_FMT = 3'b111;
`else
   localparam int         HDR_N  = 5;
   localparam logic [7:0] OPC    = 8'h0B;
   localparam logic [2:0] A_FMT  = 3'b010;
   localparam logic [2:0] RX_FMT = 3'b011;
`endif

   logic                clk = 1'b0;
   logic                arstn = 1'b0;
   logic                req_valid = 1'b0;
   logic                req_ready;
   logic [23:0]         req_addr = '0;
   logic [TB_LEN_W-1:0] req_len = '0;
   logic [7:0]          rd_data;
   logic                rd_valid;
   logic                rd_ready = 1'b1;
   logic                busy;
   logic                fl_ready = 1'b1;
   logic                fl_wr;
   logic                fl_who;
   logic [7:0]          fl_din;
   logic [2:0]          fl_format;
   logic [3:0]          fl_prescale;
   logic [7:0]          fl_dout = 8'h00;

   spif_rdseq #(.LEN_W(TB_LEN_W), .PRESCALE(4'd1), .CS_GAP(CS_GAP)) dut (
      .clk(clk), .arstn(arstn),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .busy(busy),
      .fl_ready(fl_ready), .fl_wr(fl_wr), .fl_who(fl_who), .fl_din(fl_din),
      .fl_format(fl_format), .fl_prescale(fl_prescale), .fl_dout(fl_dout)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   // Behavioural sflash: takes a strobe, drops ready a cycle later for 1..lat_max cycles.
   logic [10:0] obs_strobes[$];
   logic [10:0] exp_strobes[$];
   logic [7:0]  exp_rd[$];
   logic [7:0]  got_rd[$];
   int          strobe_idx = 0;
   int          eng_lat_max = 2;
   int          eng_cnt = 0;
   bit          eng_took = 1'b0;
   bit          eng_fixed_en = 1'b0;
   logic [7:0]  eng_fixed = 8'h00;

   always @(negedge clk) begin
      if (!arstn) begin
         fl_ready = 1'b1;
         eng_took = 1'b0;
         eng_cnt  = 0;
      end else if (eng_took) begin
         fl_ready = 1'b0;
         eng_cnt  = $urandom_range(1, eng_lat_max);
         eng_took = 1'b0;
      end else if (!fl_ready) begin
         if (eng_cnt > 1) eng_cnt--;
         else begin
            fl_ready = 1'b1;
            fl_dout  = eng_fixed_en ? eng_fixed : 8'($urandom);
            if (strobe_idx > HDR_N) exp_rd.push_back(fl_dout);
         end
      end
      if (arstn && fl_wr) begin
         obs_strobes.push_back({fl_format, fl_din});
         strobe_idx++;
         eng_took = 1'b1;
      end
   end

   // Consumer: 0 always ready, 1 random, 2 stall 50 cycles on the first byte.
   int rd_mode = 0;
   int stall_left = 0;
   bit stall_done = 1'b0;

   always @(negedge clk) begin
      case (rd_mode)
         1: rd_ready = ($urandom_range(0, 3) != 0);
         2: begin
            if (stall_left > 0) begin
               stall_left--;
               rd_ready = (stall_left == 0);
            end else if (!stall_done && rd_valid) begin
               rd_ready   = 1'b0;
               stall_left = 50;
               stall_done = 1'b1;
            end else rd_ready = 1'b1;
         end
         default: rd_ready = 1'b1;
      endcase
   end

   // Monitor: accepted bytes, strobe rules, CS# high runs, gap length.
   int   rule_viol = 0;
   int   cs_run = 0;
   int   last_cs_high = 0;
   int   gap_run = 0;
   int   last_gap = 0;
   bit   saw_nz = 1'b0;
   logic prev_wr = 1'b0;
   logic prev_ready = 1'b1;
   logic prev_arstn = 1'b0;
   logic [2:0] prev_fmt = 3'b000;

   always @(posedge clk) begin
      if (arstn && rd_valid && rd_ready) got_rd.push_back(rd_data);
      if (arstn && prev_arstn) begin
         if (fl_wr && prev_wr) rule_viol++;
         if (fl_wr && !fl_ready) rule_viol++;
         if (!prev_ready && fl_format != prev_fmt) rule_viol++;
         if (fl_wr && rd_valid && fl_format == RX_FMT) rule_viol++;
      end
      if (fl_format == 3'b000) cs_run++;
      else begin
         if (cs_run > 0) last_cs_high = cs_run;
         cs_run = 0;
      end
      if (!arstn) saw_nz = 1'b0;
      else if (busy && fl_format != 3'b000) begin
         saw_nz  = 1'b1;
         gap_run = 0;
      end else if (busy && saw_nz) gap_run++;
      else if (!busy && saw_nz) begin
         last_gap = gap_run;
         saw_nz   = 1'b0;
      end
      prev_wr    = fl_wr;
      prev_ready = fl_ready;
      prev_fmt   = fl_format;
      prev_arstn = arstn;
   end

   // Reference model: byte sequence a read of len+1 bytes at address a must produce.
   task automatic build_exp(input logic [23:0] a, input int len);
      exp_strobes.delete();
      exp_strobes.push_back({3'b010, OPC});
      exp_strobes.push_back({A_FMT, a[23:16]});
      exp_strobes.push_back({A_FMT, a[15:8]});
      exp_strobes.push_back({A_FMT, a[7:0]});
`ifdef FLASH_QUAD_EN
      exp_strobes.push_back({A_FMT, 8'h00});
      exp_strobes.push_back({RX_FMT, 8'hFF});
`endif
      exp_strobes.push_back({RX_FMT, 8'hFF});
      for (int i = 0; i <= len; i++) exp_strobes.push_back({RX_FMT, 8'hFF});
   endtask

   task automatic do_req(input logic [23:0] a, input int len);
      int cyc = 0;
      while (!req_ready && cyc < BUDGET) begin
         @(negedge clk);
         cyc++;
      end
      check("req_ready_wait", req_ready, 1);
      req_addr  = a;
      req_len   = TB_LEN_W'(len);
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("acc_busy", busy, 1);
      check("acc_req_ready", req_ready, 0);
      check("acc_format", fl_format, 3'b010);
      check("acc_wr", fl_wr, 1);
      check("acc_opcode", fl_din, OPC);
   endtask

   task automatic run_txn(input logic [23:0] a, input int len, input int rmode);
      int cyc;
      build_exp(a, len);
      obs_strobes.delete();
      exp_rd.delete();
      got_rd.delete();
      strobe_idx = 0;
      stall_done = 1'b0;
      rd_mode    = rmode;
      do_req(a, len);
      cyc = 0;
      while (busy && cyc < BUDGET) begin
         @(negedge clk);
         cyc++;
      end
      check("txn_busy_end", busy, 0);
      cyc = 0;
      while (got_rd.size() < len + 1 && cyc < BUDGET) begin
         @(negedge clk);
         cyc++;
      end
      @(negedge clk);
      check("strobe_count", obs_strobes.size(), exp_strobes.size());
      for (int i = 0; i < obs_strobes.size() && i < exp_strobes.size(); i++)
         check($sformatf("strobe%0d", i), obs_strobes[i], exp_strobes[i]);
      check("rd_count", got_rd.size(), len + 1);
      for (int i = 0; i < got_rd.size() && i < exp_rd.size(); i++)
         check($sformatf("rd_byte%0d", i), got_rd[i], exp_rd[i]);
      check("gap_cycles", last_gap, CS_GAP);
      check("idle_req_ready", req_ready, 1);
   endtask

   initial begin
      int cyc;
      repeat (3) @(negedge clk);
      check("rst_req_ready", req_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_fl_wr", fl_wr, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_fl_din", fl_din, 0);
      check("rst_fl_format", fl_format, 0);
      check("fl_prescale", fl_prescale, 4'd1);
      check("fl_who", fl_who, 0);
      arstn = 1'b1;
      repeat (2) @(negedge clk);

      eng_fixed_en = 1'b1;
      eng_fixed    = 8'hA5;
      run_txn(24'h012345, 0, 0);
      if (got_rd.size() > 0) check("first_byte_a5", got_rd[0], 8'hA5);
      eng_fixed_en = 1'b0;

      run_txn(24'h00ABCD, 3, 2);

      run_txn(24'hFFFFFF, 1, 0);

      run_txn(24'h100200, 2, 0);
      run_txn(24'h300400, 1, 0);
      check("b2b_cs_high_ge", (last_cs_high >= CS_GAP + 1), 1);

      build_exp(24'h456789, 2);
      obs_strobes.delete();
      strobe_idx = 0;
      rd_mode    = 0;
      do_req(24'h456789, 2);
      cyc = 0;
      while (strobe_idx < 3 && cyc < BUDGET) begin
         @(negedge clk);
         cyc++;
      end
      check("reach_addr_byte2", strobe_idx, 3);
      #1 arstn = 1'b0;
      #1;
      check("mid_rst_format", fl_format, 0);
      check("mid_rst_wr", fl_wr, 0);
      check("mid_rst_rd_valid", rd_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_req_ready", req_ready, 1);
      repeat (3) @(negedge clk);
      arstn = 1'b1;
      repeat (2) @(negedge clk);
      run_txn(24'h0A0B0C, 2, 0);

      eng_lat_max = 4;
      for (int k = 0; k < 6; k++)
         run_txn(24'($urandom), $urandom_range(0, 15), 1);
      run_txn(24'h7FFFFE, 15, 1);

      check("strobe_rules", rule_viol, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
